stream_sink_fifo: RTL and testbench
===================================

# stream_sink_fifo

Receive end of the valid-only stream interface driven into generated pipelines. Captures every word presented with `in_valid` (no backpressure on the input side), buffers it in a small FIFO and re-presents it on a valid/ready output so downstream logic or a bench reader can drain at its own pace. Counts accepted and dropped words and raises a sticky overflow flag when the source outruns the reader. Sits at the output of a pipeline stage (e.g. on `sig0`/valid) as the counterpart of the stimulus writer feeding the pipeline input.

## Interface
- `WIDTH`, 32, data word width
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `CNT_W`, 16, width of the word counters

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `in_data`  in  WIDTH  stream word
- `in_valid`  in  1  `in_data` valid this cycle; no ready, source never stalls
- `out_data`  out  WIDTH  head-of-FIFO word
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  reader accepts `out_data` this cycle
- `level`  out  $clog2(DEPTH)+1  entries currently held
- `overflow`  out  1  sticky: at least one word dropped
- `clr_overflow`  in  1  clears `overflow`
- `rx_count`  out  CNT_W  words accepted since reset, wraps
- `drop_count`  out  CNT_W  words dropped since reset, saturates at all-ones

## Operation
- Storage: DEPTH-entry array, write pointer and read pointer of $clog2(DEPTH)+1 bits (extra wrap bit); full = pointers equal except MSB, empty = pointers equal. Pointers wrap modulo 2·DEPTH.
- pop = `out_valid && out_ready`. `out_valid` = !empty; `out_data` = array[rd_ptr] (registered storage, combinational read of head).
- push accepted when `in_valid && (!full || pop)`: write `in_data` at wr_ptr, increment wr_ptr, `rx_count` += 1 (mod 2^CNT_W).
- Drop when `in_valid && full && !pop`: word discarded, pointers unchanged, `overflow` ← 1, `drop_count` += 1 unless already all-ones.
- `level` = wr_ptr − rd_ptr, updated every edge: +1 push only, −1 pop only, unchanged both or neither.
- `clr_overflow` clears `overflow` on the next edge; if a drop occurs the same cycle, set wins (`overflow` stays 1).
- Empty with simultaneous `in_valid`: `out_valid` is 0 that cycle, no pop, word written; no bypass path.
- `out_ready` while empty: ignored, no pointer change.
- Word order preserved exactly; no duplication, no reordering.

## Timing
- Reset (`rst`=1 at an edge): both pointers 0, `out_valid` 0, `level` 0, `overflow` 0, `rx_count` 0, `drop_count` 0; FIFO contents discarded. `out_data` undefined while `out_valid`=0.
- Reset mid-operation: all buffered words lost, counters cleared on the same edge; `in_valid` during reset ignored (not counted).
- Latency: word with `in_valid` sampled at edge k appears with `out_valid`=1 in the cycle after edge k (1 cycle) if FIFO was empty.
- Throughput: one push and one pop per cycle sustained; full FIFO with pop every cycle accepts a word every cycle without drops.
- `level`, `overflow`, counters are registered; reflect events of edge k in the cycle after k.

## Test plan
- Reset, then `in_valid` words 9, 2, idle cycle, 13 with `out_ready`=1 → `out_data` 9, 2, 13 each 1 cycle after input, `rx_count`=3, `level` returns to 0, `overflow`=0.
- `out_ready`=0, push DEPTH=8 words 1..8 → `level`=8, `out_valid`=1, `out_data`=1; then raise `out_ready` → drains 1..8 in order, `level` 0.
- Full FIFO, push 99 with `out_ready`=0 → 99 dropped, `overflow`=1, `drop_count`=1, `rx_count`=8; full FIFO, push 100 with `out_ready`=1 → 100 accepted, `level` stays 8, no drop; 100 emerges last.
- `overflow`=1, assert `clr_overflow` alone → 0 next cycle; assert `clr_overflow` on a drop cycle → stays 1, `drop_count` +1.
- Stream 20 words with `out_ready` toggling 1,0,1,0 → output order 1..20 exact, wr/rd pointers wrap past DEPTH, no drops.
- Push 5 words with `out_ready`=0, assert `rst` one cycle → `level` 0, `out_valid` 0, counters 0; next push 7 → `out_data`=7, `rx_count`=1.

Source files
------------

// File: rtl/stream_sink_fifo_if.sv
// Bundles the sink FIFO's stream input, valid/ready output and status signals.
// The master side drives the stream and the reader controls; the slave side is the FIFO.
interface stream_sink_fifo_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             clr_overflow;
    logic [CNT_W-1:0] rx_count;
    logic [CNT_W-1:0] drop_count;

    modport master (
        output in_data, in_valid, out_ready, clr_overflow,
        input  out_data, out_valid, level, overflow, rx_count, drop_count
    );

    modport slave (
        input  in_data, in_valid, out_ready, clr_overflow,
        output out_data, out_valid, level, overflow, rx_count, drop_count
    );
endinterface

// File: rtl/stream_sink_fifo.sv
// Receive end of a valid-only stream: captures every word into a small FIFO,
// re-presents it on valid/ready, and tracks accepted/dropped words plus a sticky overflow.
module stream_sink_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    stream_sink_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             r_overflow;
    logic [CNT_W-1:0] r_rx_count;
    logic [CNT_W-1:0] r_drop_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && bus.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO keeps accepting.
    assign w_push  = bus.in_valid && (!w_full || w_pop);
    assign w_drop  = bus.in_valid && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_overflow   <= 1'b0;
            r_rx_count   <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + PW'(1);
                r_rx_count <= r_rx_count + CNT_W'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            // Drop wins over a simultaneous clear so no loss goes unreported.
            if (w_drop) begin
                r_overflow   <= 1'b1;
                r_drop_count <= sat_inc(r_drop_count);
            end else if (bus.clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.out_valid  = !w_empty;
    assign bus.out_data   = r_mem[r_rd_ptr[AW-1:0]];
    assign bus.level      = r_wr_ptr - r_rd_ptr;
    assign bus.overflow   = r_overflow;
    assign bus.rx_count   = r_rx_count;
    assign bus.drop_count = r_drop_count;
endmodule

// File: tb/tb_stream_sink_fifo.sv
// Directed bench for stream_sink_fifo: vector table for fill/drain/overflow,
// plus hand sequences for a pointer-wrapping stream and a mid-run reset.
module tb_stream_sink_fifo;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic clk;
    logic rst;

    stream_sink_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    stream_sink_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          iv;
        logic [31:0] d;
        bit          rdy;
        bit          clr;
        bit          eov;
        logic [31:0] eod;
        int          elvl;
        bit          eovf;
        int          erx;
        int          edrp;
    } vec_t;

    vec_t tbl[$];
    int   total;
    int   bad;

    function automatic void add(bit r, bit iv, logic [31:0] d, bit rdy, bit clr,
                                bit eov, logic [31:0] eod, int elvl, bit eovf,
                                int erx, int edrp);
        vec_t v;
        v.rst = r; v.iv = iv; v.d = d; v.rdy = rdy; v.clr = clr;
        v.eov = eov; v.eod = eod; v.elvl = elvl; v.eovf = eovf;
        v.erx = erx; v.edrp = edrp;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, let one rising edge pass, check state after it.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst              = v.rst;
        bus.in_valid     = v.iv;
        bus.in_data      = v.d;
        bus.out_ready    = v.rdy;
        bus.clr_overflow = v.clr;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d out_valid", idx), 32'(bus.out_valid), 32'(v.eov));
        if (v.eov)
            chk($sformatf("v%0d out_data", idx), bus.out_data, v.eod);
        chk($sformatf("v%0d level", idx), 32'(bus.level), 32'(v.elvl));
        chk($sformatf("v%0d overflow", idx), 32'(bus.overflow), 32'(v.eovf));
        chk($sformatf("v%0d rx_count", idx), 32'(bus.rx_count), 32'(v.erx));
        chk($sformatf("v%0d drop_count", idx), 32'(bus.drop_count), 32'(v.edrp));
    endtask

    initial begin
        int next_in;
        int exp_out;
        int popped;
        vec_t v;

        total = 0;
        bad   = 0;
        rst              = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.out_ready    = 1'b0;
        bus.clr_overflow = 1'b0;

        // Reset, then 9, 2, idle, 13 with reader always ready.
        add(1, 0, 0,  1, 0,  0, 0,  0, 0, 0, 0);
        add(0, 1, 9,  1, 0,  1, 9,  1, 0, 1, 0);
        add(0, 1, 2,  1, 0,  1, 2,  1, 0, 2, 0);
        add(0, 0, 0,  1, 0,  0, 0,  0, 0, 2, 0);
        add(0, 1, 13, 1, 0,  1, 13, 1, 0, 3, 0);
        add(0, 0, 0,  1, 0,  0, 0,  0, 0, 3, 0);
        // Fill 1..8 with reader stalled, then drain.
        for (int k = 1; k <= 8; k++)
            add(0, 1, k, 0, 0,  1, 1, k, 0, 3 + k, 0);
        for (int j = 1; j <= 8; j++)
            add(0, 0, 0, 1, 0,  j < 8, j + 1, 8 - j, 0, 11, 0);
        // Fresh fill, drop 99, accept 100 via same-cycle pop, drain to 100.
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++)
            add(0, 1, k, 0, 0,  1, 1, k, 0, k, 0);
        add(0, 1, 99,  0, 0,  1, 1, 8, 1, 8, 1);
        add(0, 1, 100, 1, 0,  1, 2, 8, 1, 9, 1);
        for (int j = 1; j <= 8; j++)
            add(0, 0, 0, 1, 0,  j < 8, (j <= 6) ? j + 2 : 100, 8 - j, 1, 9, 1);
        // Overflow clear alone, then clear racing a drop.
        add(0, 0, 0, 0, 1,  0, 0, 0, 0, 9, 1);
        for (int k = 1; k <= 8; k++)
            add(0, 1, 20 + k, 0, 0,  1, 21, k, 0, 9 + k, 1);
        add(0, 1, 55, 0, 1,  1, 21, 8, 1, 17, 2);
        add(0, 0, 0,  0, 1,  1, 21, 8, 0, 17, 2);
        add(1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0);

        foreach (tbl[i])
            apply(tbl[i], i);

        // 20-word stream: push on odd cycles, ready on even, pointers wrap twice.
        next_in = 1;
        exp_out = 1;
        popped  = 0;
        for (int c = 0; c < 80 && popped < 20; c++) begin
            @(negedge clk);
            rst              = 1'b0;
            bus.clr_overflow = 1'b0;
            bus.in_valid     = (c % 2 == 1) && (next_in <= 20);
            bus.in_data      = next_in;
            bus.out_ready    = (c % 2 == 0);
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("stream word %0d", exp_out), bus.out_data, exp_out);
                exp_out++;
                popped++;
            end
            if (bus.in_valid)
                next_in++;
            @(posedge clk);
        end
        #1;
        chk("stream popped", popped, 20);
        chk("stream rx_count", 32'(bus.rx_count), 20);
        chk("stream drop_count", 32'(bus.drop_count), 0);
        chk("stream overflow", 32'(bus.overflow), 0);
        chk("stream level", 32'(bus.level), 0);

        // Reset mid-operation with in_valid high during reset.
        for (int k = 1; k <= 5; k++) begin
            v = '{rst:0, iv:1, d:k, rdy:0, clr:0, eov:1, eod:1, elvl:k, eovf:0, erx:20 + k, edrp:0};
            apply(v, 100 + k);
        end
        v = '{rst:1, iv:1, d:77, rdy:0, clr:0, eov:0, eod:0, elvl:0, eovf:0, erx:0, edrp:0};
        apply(v, 200);
        v = '{rst:0, iv:1, d:7, rdy:0, clr:0, eov:1, eod:7, elvl:1, eovf:0, erx:1, edrp:0};
        apply(v, 201);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
